// File: rtl/key_conditioner_pkg.sv
// Shared widths and project-wide defaults for the key input front end.
// Widths used by every file of the key conditioner slice live here.
package key_conditioner_pkg;

  localparam int NOTE_KEY_BITS   = 7;
  localparam int LENGTH_KEY_BITS = 3;
  localparam int NOTE_BITS       = 3;
  localparam int CLOCK_BITS      = 32;

  // 20 ms at 100 MHz; counter width must hold DEBOUNCE_CYCLES-1.
  localparam int KEY_DEBOUNCE_CYCLES = 2000000;
  localparam int KEY_CNT_W           = 21;

  localparam int KEY_REPEAT_DELAY  = 50000000;
  localparam int KEY_REPEAT_PERIOD = 10000000;

  // Control keys carried after the note and length bits in the key vector.
  localparam int CTL_KEY_BITS = 3;
  localparam int KEY_BITS     = NOTE_KEY_BITS + LENGTH_KEY_BITS + CTL_KEY_BITS;

  typedef enum logic [1:0] {
    CTL_OCT_UP   = 2'd0,
    CTL_OCT_DOWN = 2'd1,
    CTL_HIT      = 2'd2
  } ctl_key_e;

endpackage

// File: rtl/key_debounce.sv
// Single-bit two-flop synchroniser followed by a hold-time debounce counter.
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_W           = KEY_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cnt_w_check
    $error("key_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      // Any sample matching the current level restarts the hold window.
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounced key levels, edge pulses and a timestamped note-press event queue of depth one.
// Optional auto-repeat on the octave keys is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_W           = KEY_CNT_W,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NOTE_KEY_BITS-1:0]   raw_note,
  input  logic [LENGTH_KEY_BITS-1:0] raw_length,
  input  logic                       raw_oct_up,
  input  logic                       raw_oct_down,
  input  logic                       raw_hit,
  input  logic [CLOCK_BITS-1:0]      system_clock,
  output logic [NOTE_KEY_BITS-1:0]   note_key,
  output logic [LENGTH_KEY_BITS-1:0] length_key,
  output logic                       oct_up,
  output logic                       oct_down,
  output logic                       en_hit,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [NOTE_BITS-1:0]       ev_note,
  output logic [CLOCK_BITS-1:0]      ev_clock,
  output logic                       ev_overflow
);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_check
    $error("key_conditioner: repeat timing parameters must be positive");
  end

  logic [KEY_BITS-1:0]      raw_all;
  logic [KEY_BITS-1:0]      stable_all;
  logic [NOTE_KEY_BITS-1:0] note_stable;
  logic [NOTE_KEY_BITS-1:0] note_d;
  logic [NOTE_KEY_BITS-1:0] note_rise;
  logic [CTL_KEY_BITS-1:0]  ctl_stable;
  logic [CTL_KEY_BITS-1:0]  ctl_d;
  logic [CTL_KEY_BITS-1:0]  ctl_rise;
  logic [NOTE_BITS-1:0]     new_note;
  logic                     press;

  assign raw_all = {raw_hit, raw_oct_down, raw_oct_up, raw_length, raw_note};

  for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_all[i]),
      .stable (stable_all[i])
    );
  end

  assign note_stable = stable_all[NOTE_KEY_BITS-1:0];
  assign length_key  = stable_all[NOTE_KEY_BITS +: LENGTH_KEY_BITS];
  assign ctl_stable  = stable_all[KEY_BITS-1 -: CTL_KEY_BITS];
  assign note_key    = note_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_d <= '0;
      ctl_d  <= '0;
    end else begin
      note_d <= note_stable;
      ctl_d  <= ctl_stable;
    end
  end

  assign note_rise = note_stable & ~note_d;
  assign ctl_rise  = ctl_stable & ~ctl_d;
  assign press     = |note_rise;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = CNT_W + 6;

  logic [1:0][REP_W-1:0] rep_cnt;
  logic [1:0]            rep_fire;

  // Down-counter reloads with the initial delay while released, then the period after each fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!ctl_stable[k]) begin
          rep_cnt[k] <= REP_W'(REPEAT_DELAY - 1);
        end else if (rep_cnt[k] == '0) begin
          rep_cnt[k] <= REP_W'(REPEAT_PERIOD - 1);
        end else begin
          rep_cnt[k] <= rep_cnt[k] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    rep_fire = '0;
    for (int k = 0; k < 2; k++) begin
      rep_fire[k] = ctl_stable[k] && (rep_cnt[k] == '0);
    end
  end

  assign oct_up   = ctl_rise[CTL_OCT_UP] | rep_fire[CTL_OCT_UP];
  assign oct_down = ctl_rise[CTL_OCT_DOWN] | rep_fire[CTL_OCT_DOWN];
`else
  assign oct_up   = ctl_rise[CTL_OCT_UP];
  assign oct_down = ctl_rise[CTL_OCT_DOWN];
`endif

  assign en_hit = ctl_rise[CTL_HIT];

  // Lowest index wins among simultaneous rises; the rest are silently dropped.
  always_comb begin
    new_note = '0;
    for (int i = NOTE_KEY_BITS - 1; i >= 0; i--) begin
      if (note_rise[i]) new_note = NOTE_BITS'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid    <= 1'b0;
      ev_note     <= '0;
      ev_clock    <= '0;
      ev_overflow <= 1'b0;
    end else if (press && (!ev_valid || ev_ready)) begin
      ev_valid <= 1'b1;
      ev_note  <= new_note;
      ev_clock <= system_clock;
    end else if (press) begin
      ev_overflow <= 1'b1;
    end else if (ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with a window-based debounce reference model.
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  localparam int DB = 4;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NOTE_KEY_BITS-1:0]   raw_note = '0;
  logic [LENGTH_KEY_BITS-1:0] raw_length = '0;
  logic                       raw_oct_up = 1'b0;
  logic                       raw_oct_down = 1'b0;
  logic                       raw_hit = 1'b0;
  logic [CLOCK_BITS-1:0]      system_clock = '0;
  logic [NOTE_KEY_BITS-1:0]   note_key;
  logic [LENGTH_KEY_BITS-1:0] length_key;
  logic                       oct_up, oct_down, en_hit;
  logic                       ev_valid;
  logic                       ev_ready = 1'b0;
  logic [NOTE_BITS-1:0]       ev_note;
  logic [CLOCK_BITS-1:0]      ev_clock;
  logic                       ev_overflow;

  key_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (3),
    .REPEAT_DELAY    (40),
    .REPEAT_PERIOD   (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_note     (raw_note),
    .raw_length   (raw_length),
    .raw_oct_up   (raw_oct_up),
    .raw_oct_down (raw_oct_down),
    .raw_hit      (raw_hit),
    .system_clock (system_clock),
    .note_key     (note_key),
    .length_key   (length_key),
    .oct_up       (oct_up),
    .oct_down     (oct_down),
    .en_hit       (en_hit),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note      (ev_note),
    .ev_clock     (ev_clock),
    .ev_overflow  (ev_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit clk_run  = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a key level flips once the last DB synchronised samples all disagree with it.
  logic [KEY_BITS-1:0]   m_stable, m_prev;
  logic [KEY_BITS-1:0]   m_hist[$];
  logic                  m_valid, m_ovf;
  logic [NOTE_BITS-1:0]  m_note;
  logic [CLOCK_BITS-1:0] m_clock;

  task automatic model_reset();
    m_stable = '0;
    m_prev   = '0;
    m_hist.delete();
    for (int i = 0; i < DB + 2; i++) m_hist.push_back('0);
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_note  = '0;
    m_clock = '0;
  endtask

  task automatic model_step();
    logic [KEY_BITS-1:0]      rise, flip;
    logic [NOTE_KEY_BITS-1:0] nrise;
    int                       first;
    rise  = m_stable & ~m_prev;
    nrise = rise[NOTE_KEY_BITS-1:0];
    if (nrise != '0) begin
      if (!m_valid || ev_ready) begin
        first = -1;
        for (int i = 0; i < NOTE_KEY_BITS; i++)
          if (nrise[i] && first < 0) first = i;
        m_valid = 1'b1;
        m_note  = NOTE_BITS'(first + 1);
        m_clock = system_clock;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (ev_ready) begin
      m_valid = 1'b0;
    end
    m_prev = m_stable;
    m_hist.push_back({raw_hit, raw_oct_down, raw_oct_up, raw_length, raw_note});
    void'(m_hist.pop_front());
    flip = '1;
    for (int i = 0; i < DB; i++) flip &= m_hist[i] ^ m_stable;
    m_stable ^= flip;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [KEY_BITS-1:0] er;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        er = m_stable & ~m_prev;
        check("m_note_key", note_key, m_stable[NOTE_KEY_BITS-1:0]);
        check("m_length_key", length_key, m_stable[NOTE_KEY_BITS +: LENGTH_KEY_BITS]);
        check("m_oct_up", oct_up, er[KEY_BITS-3]);
        check("m_oct_down", oct_down, er[KEY_BITS-2]);
        check("m_en_hit", en_hit, er[KEY_BITS-1]);
        check("m_ev_valid", ev_valid, m_valid);
        check("m_ev_note", ev_note, m_note);
        check("m_ev_clock", ev_clock, m_clock);
        check("m_ev_overflow", ev_overflow, m_ovf);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (clk_run) system_clock++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_note_key"}, note_key, 0);
    check({tag, "_length_key"}, length_key, 0);
    check({tag, "_pulses"}, {oct_up, oct_down, en_hit}, 0);
    check({tag, "_ev_valid"}, ev_valid, 0);
    check({tag, "_ev_note"}, ev_note, 0);
    check({tag, "_ev_clock"}, ev_clock, 0);
    check({tag, "_ev_overflow"}, ev_overflow, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int found = 0;
    for (int k = 0; k < 16 && found == 0; k++) begin
      tick();
      if (ev_valid) found = 1;
    end
    check({tag, "_timeout"}, found, 1);
  endtask

  initial begin
    int lat, cnt, hi;
    logic [CLOCK_BITS-1:0] exp_clk;
    logic [KEY_BITS-1:0]   rv;

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_release");

    // Octave-up press latency, pulse width, and silent release.
    raw_oct_up = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick();
      if (oct_up) lat = k;
    end
    check("oct_up_latency", lat, 6);
    tick();
    check("oct_up_width", oct_up, 0);
    raw_oct_up = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt += int'(oct_up);
    end
    check("oct_up_release_pulses", cnt, 0);

    // Bouncing note 3 then held.
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      raw_note[2] = (k % 2 == 0);
      tick();
      hi += int'(note_key[2]);
    end
    check("bounce_no_level", hi, 0);
    raw_note[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick();
      if (note_key[2]) lat = k;
    end
    check("bounce_hold_latency", lat, 6);
    tick();
    check("bounce_ev_valid", ev_valid, 1);
    check("bounce_ev_note", ev_note, 3);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt += int'(ev_valid);
    end
    check("bounce_single_event", cnt, 0);
    raw_note[2] = 1'b0;
    repeat (10) tick();

    // Simultaneous notes 1 and 5 with a frozen timestamp.
    do_reset();
    clk_run = 1'b0;
    system_clock = 32'h123;
    raw_note = 7'b0010001;
    wait_valid("simul");
    check("simul_ev_note", ev_note, 1);
    check("simul_ev_clock", ev_clock, 32'h123);
    check("simul_ev_overflow", ev_overflow, 0);
    clk_run = 1'b1;
    raw_note = '0;
    repeat (10) tick();
    raw_note[4] = 1'b1;
    repeat (10) tick();
    check("ovf_ev_valid", ev_valid, 1);
    check("ovf_ev_note", ev_note, 1);
    check("ovf_ev_clock", ev_clock, 32'h123);
    check("ovf_flag", ev_overflow, 1);
    raw_note = '0;
    repeat (10) tick();
    check("ovf_sticky", ev_overflow, 1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("ovf_consumed", ev_valid, 0);

    // Accept and reload in the same cycle.
    do_reset();
    raw_note[1] = 1'b1;
    wait_valid("reload_first");
    check("reload_first_note", ev_note, 2);
    raw_note[5] = 1'b1;
    repeat (6) tick();
    exp_clk  = system_clock;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("reload_ev_valid", ev_valid, 1);
    check("reload_ev_note", ev_note, 6);
    check("reload_ev_clock", ev_clock, exp_clk);
    check("reload_no_ovf", ev_overflow, 0);
    raw_note = '0;
    ev_ready = 1'b1;
    repeat (10) tick();
    ev_ready = 1'b0;

    // Reset in the middle of a debounce window.
    do_reset();
    raw_oct_up = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick();
      if (oct_up) lat = k;
    end
    check("mid_reset_latency", lat, 6);
    raw_oct_up = 1'b0;
    repeat (10) tick();

    // Random traffic against the model, with the timestamp wrapping.
    do_reset();
    system_clock = 32'hFFFF_FF00;
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < KEY_BITS; b++)
        if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
      {raw_hit, raw_oct_down, raw_oct_up, raw_length, raw_note} = rv;
      ev_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
